spi_lcd_receiver: RTL

SPI_LCD_RECEIVER -- requirements
Module: spi_lcd_receiver

---
 rtl/spi_lcd_receiver_pkg.sv | 37 +++
 rtl/spi_lcd_receiver_if.sv | 29 ++
 rtl/spi_lcd_receiver_edge_sync.sv | 58 +++++
 rtl/spi_lcd_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_receiver_pkg.sv
// rtl/spi_lcd_receiver_pkg.sv - shared geometry defaults, command opcodes and receiver FSM encoding
//
// Purpose: constants shared by the SPI LCD receiver files.
//   COLS_DEF / ROWS_DEF  : default frame-buffer geometry (columns per bank, banks)
//   *_MASK / *_VAL       : command opcode match patterns
//   rx_state_e           : receiver FSM state encoding
package spi_lcd_receiver_pkg;

    localparam int COLS_DEF = 84;
    localparam int ROWS_DEF = 6;

    // Function set 0b00100PVH, accepted in both instruction sets.
    localparam logic [7:0] FSET_MASK = 8'hF8;
    localparam logic [7:0] FSET_VAL  = 8'h20;
    // Display control 0b00001D0E.
    localparam logic [7:0] DCTL_MASK = 8'hFA;
    localparam logic [7:0] DCTL_VAL  = 8'h08;
    // Set Y address 0b01000yyy.
    localparam logic [7:0] SETY_MASK = 8'hF8;
    localparam logic [7:0] SETY_VAL  = 8'h40;
    // Set X address 0b1xxxxxxx.
    localparam logic [7:0] SETX_MASK = 8'h80;
    localparam logic [7:0] SETX_VAL  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } rx_state_e;

    function automatic logic cmd_match(input logic [7:0] b,
                                       input logic [7:0] mask,
                                       input logic [7:0] val);
        return (b & mask) == val;
    endfunction

endpackage

// File: rtl/spi_lcd_receiver_if.sv
// rtl/spi_lcd_receiver_if.sv - SPI input lines and frame-buffer write port bundle
//
// Signals:
//   sclk, sce, mosi, dc           : SPI serial clock, chip enable (low), data, data/command
//   mem_we, mem_addr, mem_wdata   : frame-buffer write strobe, address, data
// Modports:
//   master : drives the SPI lines, observes the frame-buffer port (host / bench side)
//   slave  : receives the SPI lines, drives the frame-buffer port (receiver side)
interface spi_lcd_receiver_if;

    logic       sclk;
    logic       sce;
    logic       mosi;
    logic       dc;
    logic       mem_we;
    logic [8:0] mem_addr;
    logic [7:0] mem_wdata;

    modport master (
        output sclk, sce, mosi, dc,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  sclk, sce, mosi, dc,
        output mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/spi_lcd_receiver_edge_sync.sv
// rtl/spi_lcd_receiver_edge_sync.sv - 2-flop synchronizers for the SPI lines plus sclk rising-edge detect
//
// Ports:
//   clk, rst_n              : system clock, asynchronous active-low reset
//   sclk, sce, mosi, dc     : raw asynchronous SPI inputs
//   sclk_rise               : one-cycle pulse on a synchronized sclk rising edge
//   sce_s, mosi_s, dc_s     : synchronized sce, mosi, dc
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic sce,
    input  logic mosi,
    input  logic dc,
    output logic sclk_rise,
    output logic sce_s,
    output logic mosi_s,
    output logic dc_s
);

    logic [1:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] sce_sync_q,  sce_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] dc_sync_q,   dc_sync_d;
    logic       sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[0], sclk};
        sce_sync_d  = {sce_sync_q[0],  sce};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        dc_sync_d   = {dc_sync_q[0],   dc};
        sclk_prev_d = sclk_sync_q[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            sce_sync_q  <= '0;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            sce_sync_q  <= sce_sync_d;
            mosi_sync_q <= mosi_sync_d;
            dc_sync_q   <= dc_sync_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // All four lines see the same two-flop delay, so mosi/dc keep their
    // setup relationship to sclk after synchronization.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign sce_s     = sce_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign dc_s      = dc_sync_q[1];

endmodule

// File: rtl/spi_lcd_receiver.sv
// rtl/spi_lcd_receiver.sv - SPI LCD controller front end: byte receiver, command decoder, frame-buffer addressing
//
// Ports:
//   clk, rst_n                 : system clock (>= 4x sclk), asynchronous active-low reset
//   bus (slave)                : sclk/sce/mosi/dc in, mem_we/mem_addr/mem_wdata out
//   rx_byte, rx_valid          : last complete byte, one-cycle pulse per byte
//   rx_is_data                 : dc sampled with the last bit of rx_byte
//   cur_x, cur_y               : current frame-buffer column / bank
//   power_down, vertical, ext_mode : function-set bits PD, V, H
//   disp_mode                  : display-control bits {D,E}
//   frame_err                  : sticky, sce deasserted mid-byte
module spi_lcd_receiver
    import spi_lcd_receiver_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_lcd_receiver_if.slave    bus,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 rx_is_data,
    output logic [6:0]           cur_x,
    output logic [2:0]           cur_y,
    output logic                 power_down,
    output logic                 vertical,
    output logic                 ext_mode,
    output logic [1:0]           disp_mode,
    output logic                 frame_err
);

    logic sclk_rise, sce_s, mosi_s, dc_s;

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (bus.sclk),
        .sce       (bus.sce),
        .mosi      (bus.mosi),
        .dc        (bus.dc),
        .sclk_rise (sclk_rise),
        .sce_s     (sce_s),
        .mosi_s    (mosi_s),
        .dc_s      (dc_s)
    );

    rx_state_e  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_is_data_q, rx_is_data_d;
    logic       mem_we_q, mem_we_d;
    logic [8:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic [6:0] cur_x_q, cur_x_d;
    logic [2:0] cur_y_q, cur_y_d;
    logic       pd_q, pd_d;
    logic       v_q, v_d;
    logic       h_q, h_d;
    logic [1:0] disp_q, disp_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] byte_in;

    logic x_last, y_last;
    assign x_last = (int'(cur_x_q) == COLS - 1);
    assign y_last = (int'(cur_y_q) == ROWS - 1);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rx_byte_d    = rx_byte_q;
        rx_valid_d   = 1'b0;
        rx_is_data_d = rx_is_data_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        pd_d         = pd_q;
        v_d          = v_q;
        h_d          = h_q;
        disp_d       = disp_q;
        frame_err_d  = frame_err_q;
        byte_in      = {shift_q, mosi_s};

        case (state_q)
            ST_IDLE:   if (!sce_s) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sce_s)
                    state_d = ST_IDLE;
                else if (sclk_rise && bit_cnt_q == 3'd7)
                    state_d = ST_DECODE;
            end
            ST_DECODE: state_d = sce_s ? ST_IDLE : ST_SHIFT;
            default:   state_d = ST_IDLE;
        endcase

        if (sce_s) begin
            // Deselect mid-byte drops the partial byte and flags it.
            if (bit_cnt_q != 3'd0)
                frame_err_d = 1'b1;
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                rx_byte_d    = byte_in;
                rx_is_data_d = dc_s;
                rx_valid_d   = 1'b1;
                if (dc_s) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = 9'(int'(cur_y_q) * COLS + int'(cur_x_q));
                    mem_wdata_d = byte_in;
                    if (!v_q) begin
                        if (x_last) begin
                            cur_x_d = 7'd0;
                            cur_y_d = y_last ? 3'd0 : cur_y_q + 3'd1;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else begin
                        if (y_last) begin
                            cur_y_d = 3'd0;
                            cur_x_d = x_last ? 7'd0 : cur_x_q + 7'd1;
                        end else begin
                            cur_y_d = cur_y_q + 3'd1;
                        end
                    end
                end else if (cmd_match(byte_in, FSET_MASK, FSET_VAL)) begin
                    pd_d = byte_in[2];
                    v_d  = byte_in[1];
                    h_d  = byte_in[0];
                end else if (!h_q) begin
                    // Basic instruction set; the extended set has no effect here.
                    if (cmd_match(byte_in, DCTL_MASK, DCTL_VAL))
                        disp_d = {byte_in[2], byte_in[0]};
                    else if (cmd_match(byte_in, SETY_MASK, SETY_VAL)) begin
                        if (int'(byte_in[2:0]) < ROWS)
                            cur_y_d = byte_in[2:0];
                    end else if (cmd_match(byte_in, SETX_MASK, SETX_VAL)) begin
                        if (int'(byte_in[6:0]) < COLS)
                            cur_x_d = byte_in[6:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_is_data_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 9'd0;
            mem_wdata_q  <= 8'd0;
            cur_x_q      <= 7'd0;
            cur_y_q      <= 3'd0;
            pd_q         <= 1'b1;
            v_q          <= 1'b0;
            h_q          <= 1'b0;
            disp_q       <= 2'd0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_valid_q   <= rx_valid_d;
            rx_is_data_q <= rx_is_data_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pd_q         <= pd_d;
            v_q          <= v_d;
            h_q          <= h_d;
            disp_q       <= disp_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_valid      = rx_valid_q;
    assign rx_is_data    = rx_is_data_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cur_x         = cur_x_q;
    assign cur_y         = cur_y_q;
    assign power_down    = pd_q;
    assign vertical      = v_q;
    assign ext_mode      = h_q;
    assign disp_mode     = disp_q;
    assign frame_err     = frame_err_q;

endmodule
